// File: rtl/multiplication_block_if.sv
// ============================================================================
// | Module   : multiplication_block_if                                        |
// | Purpose  : Request/response bundle for the iterative RV32M multiplier.    |
// |            The master side issues a request (operands, operation, strobe) |
// |            and observes the result, the one-shot completion pulse and the  |
// |            busy indication. The multiplier itself is the slave side.       |
// | Signals  : multiplicand [XLEN]  rs1 operand          (master -> slave)    |
// |            multiplier   [XLEN]  rs2 operand          (master -> slave)    |
// |            data_valid           request strobe       (master -> slave)    |
// |            operation    [2]     00 MUL 01 MULH 10 MULHSU 11 MULHU         |
// |            product_o    [XLEN]  result, held         (slave -> master)    |
// |            data_ready           one-cycle done pulse (slave -> master)    |
// |            busy                 operation in flight  (slave -> master)    |
// | Revision : 1.0 - initial release                                          |
// ============================================================================
`default_nettype none

interface multiplication_block_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] multiplicand;
    logic [XLEN-1:0] multiplier;
    logic            data_valid;
    logic [1:0]      operation;
    logic [XLEN-1:0] product_o;
    logic            data_ready;
    logic            busy;

    modport master (
        output multiplicand,
        output multiplier,
        output data_valid,
        output operation,
        input  product_o,
        input  data_ready,
        input  busy
    );

    modport slave (
        input  multiplicand,
        input  multiplier,
        input  data_valid,
        input  operation,
        output product_o,
        output data_ready,
        output busy
    );
endinterface

`default_nettype wire

// File: rtl/multiplication_block.sv
// ============================================================================
// | Module   : multiplication_block                                          |
// | Purpose  : Iterative radix-2 shift-add multiplier for RV32M MUL, MULH,    |
// |            MULHSU and MULHU. Operands are converted to magnitudes at      |
// |            capture, multiplied unsigned over XLEN cycles, and the sign is  |
// |            restored by a full-width negation in the single DONE cycle.    |
// | Ports    : CLK          in   clock, rising edge                          |
// |            rst_n        in   asynchronous active-low reset               |
// |            bus          slave modport of multiplication_block_if         |
// |              multiplicand/multiplier/operation/data_valid  : request     |
// |              product_o/data_ready/busy                     : response    |
// | Options  : MUL_EARLY_ZERO_EN - when defined, a zero operand at capture    |
// |            bypasses the iterations and completes one cycle later.        |
// | Revision : 1.0 - initial release                                          |
// ============================================================================
`default_nettype none

module multiplication_block #(
    parameter int XLEN        = 32,
    parameter int COUNT_WIDTH = $clog2(XLEN)
) (
    input  wire                   CLK,
    input  wire                   rst_n,
    multiplication_block_if.slave bus
);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULHU  = 2'b11;
    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(XLEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                   state_q,      state_d;
    logic [2*XLEN-1:0]        mcand_q,      mcand_d;
    logic [XLEN-1:0]          mplr_q,       mplr_d;
    logic [2*XLEN-1:0]        acc_q,        acc_d;
    logic [COUNT_WIDTH-1:0]   count_q,      count_d;
    logic                     neg_q,        neg_d;
    logic [1:0]               op_q,         op_d;
    logic [XLEN-1:0]          product_q,    product_d;
    logic                     data_ready_q, data_ready_d;

    // Operand conditioning for the capture cycle
    logic                     w_rs1_signed;
    logic                     w_rs2_signed;
    logic                     w_rs1_neg;
    logic                     w_rs2_neg;
    logic [XLEN-1:0]          w_rs1_abs;
    logic [XLEN-1:0]          w_rs2_abs;
    logic [2*XLEN-1:0]        w_result;

    // rs1 is signed for everything except MULHU; rs2 only for MUL/MULH.
    assign w_rs1_signed = (bus.operation != OP_MULHU);
    assign w_rs2_signed = ~bus.operation[1];
    assign w_rs1_neg    = w_rs1_signed & bus.multiplicand[XLEN-1];
    assign w_rs2_neg    = w_rs2_signed & bus.multiplier[XLEN-1];
    // Negating the most negative value yields 2^(XLEN-1), which is exactly
    // the required magnitude when read as unsigned.
    assign w_rs1_abs    = w_rs1_neg ? (~bus.multiplicand + 1'b1) : bus.multiplicand;
    assign w_rs2_abs    = w_rs2_neg ? (~bus.multiplier + 1'b1)   : bus.multiplier;
    assign w_result     = neg_q ? (~acc_q + 1'b1) : acc_q;

    always_comb begin
        state_d      = state_q;
        mcand_d      = mcand_q;
        mplr_d       = mplr_q;
        acc_d        = acc_q;
        count_d      = count_q;
        neg_d        = neg_q;
        op_d         = op_q;
        product_d    = product_q;
        data_ready_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A request coinciding with the completion pulse is dropped so
                // the stall logic never sees a capture and a done together.
                if (bus.data_valid && !data_ready_q) begin
                    mcand_d = {{XLEN{1'b0}}, w_rs1_abs};
                    mplr_d  = w_rs2_abs;
                    acc_d   = '0;
                    count_d = '0;
                    neg_d   = w_rs1_neg ^ w_rs2_neg;
                    op_d    = bus.operation;
                    state_d = ST_BUSY;
`ifdef MUL_EARLY_ZERO_EN
                    // Accumulator is already zero; negation of zero is zero.
                    if ((bus.multiplicand == '0) || (bus.multiplier == '0)) begin
                        state_d = ST_DONE;
                    end
`endif
                end
            end

            ST_BUSY: begin
                // The multiplicand register carries the current shift position.
                if (mplr_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                if (count_q == COUNT_LAST) begin
                    count_d = '0;
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end

            ST_DONE: begin
                product_d    = (op_q == OP_MUL) ? w_result[XLEN-1:0]
                                                : w_result[2*XLEN-1:XLEN];
                data_ready_d = 1'b1;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mcand_q      <= '0;
            mplr_q       <= '0;
            acc_q        <= '0;
            count_q      <= '0;
            neg_q        <= 1'b0;
            op_q         <= 2'b00;
            product_q    <= '0;
            data_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mcand_q      <= mcand_d;
            mplr_q       <= mplr_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            neg_q        <= neg_d;
            op_q         <= op_d;
            product_q    <= product_d;
            data_ready_q <= data_ready_d;
        end
    end

    assign bus.product_o  = product_q;
    assign bus.data_ready = data_ready_q;
    // Busy spans capture through the completion pulse, inclusive.
    assign bus.busy       = (state_q != ST_IDLE) | data_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_multiplication_block.sv
// ============================================================================
// | Module   : tb_multiplication_block                                       |
// | Purpose  : Self-checking bench for multiplication_block: directed RV32M   |
// |            corner cases, randomized operations against a 66-bit signed    |
// |            arithmetic reference, handshake ignore rules, async abort,     |
// |            continuous requests and zero operands (MUL_EARLY_ZERO_EN).     |
// | Revision : 1.0 - initial release                                          |
// ============================================================================
`default_nettype none

module tb_multiplication_block;

    localparam int XLEN = 32;

`ifdef MUL_EARLY_ZERO_EN
    localparam bit EARLY_ZERO = 1'b1;
`else
    localparam bit EARLY_ZERO = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    multiplication_block_if #(.XLEN(XLEN)) mb ();

    multiplication_block #(.XLEN(XLEN)) dut (
        .CLK   (clk),
        .rst_n (rst_n),
        .bus   (mb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: sign/zero extend to 66 bits and multiply with plain arithmetic.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [65:0] ea;
        logic signed [65:0] eb;
        logic signed [65:0] p;
        ea = (op != 2'b11) ? {{34{a[31]}}, a} : {34'd0, a};
        eb = (op[1] == 1'b0) ? {{34{b[31]}}, b} : {34'd0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
        if (EARLY_ZERO && ((a == 32'd0) || (b == 32'd0))) return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one request, scramble the inputs right after capture, and watch a
    // bounded window. lat is the edge index (after capture) of the first pulse.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int pulses,
                          output logic [31:0] held);
        @(negedge clk);
        mb.operation    = op;
        mb.multiplicand = a;
        mb.multiplier   = b;
        mb.data_valid   = 1'b1;
        @(posedge clk);
        #1;
        mb.data_valid   = 1'b0;
        mb.multiplicand = $urandom;
        mb.multiplier   = $urandom;
        mb.operation    = 2'($urandom);
        lat    = -1;
        pulses = 0;
        res    = 32'hDEAD_BEEF;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            if (mb.data_ready) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    res = mb.product_o;
                end
            end
        end
        held = mb.product_o;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        mb.data_valid   = 1'b0;
        mb.multiplicand = '0;
        mb.multiplier   = '0;
        mb.operation    = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({mb.product_o, mb.data_ready, mb.busy} !== 34'd0) begin
            $display("FAIL reset_outputs: product_o=%h data_ready=%b busy=%b, required 0/0/0",
                     mb.product_o, mb.data_ready, mb.busy);
        end else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [1:0]  ops  [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10};
        logic [31:0] as   [5] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
        logic [31:0] bs   [5] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'h8000_0000};
        logic [31:0] exps [5] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                  32'h0000_0001};
        logic [31:0] res, held;
        int lat, pulses;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat, pulses, held);
            total_cnt++;
            if (res !== exps[i]) begin
                $display("FAIL directed_%0d result: got %h, required %h", i, res, exps[i]);
            end else pass_cnt++;
            if (i == 0) begin
                total_cnt++;
                if (lat != XLEN + 1 || pulses != 1) begin
                    $display("FAIL directed_latency: got lat=%0d pulses=%0d, required lat=%0d pulses=1",
                             lat, pulses, XLEN + 1);
                end else pass_cnt++;
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b, res, held, exp;
        int lat, pulses;
        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom);
            a   = pick_operand();
            b   = pick_operand();
            exp = ref_mul(op, a, b);
            run_op(op, a, b, res, lat, pulses, held);
            total_cnt++;
            if (res !== exp || held !== exp) begin
                $display("FAIL random_%0d op=%0d a=%h b=%h: got %h (held %h), required %h",
                         i, op, a, b, res, held, exp);
            end else pass_cnt++;
            total_cnt++;
            if (lat != exp_latency(a, b) || pulses != 1) begin
                $display("FAIL random_%0d timing: got lat=%0d pulses=%0d, required lat=%0d pulses=1",
                         i, lat, pulses, exp_latency(a, b));
            end else pass_cnt++;
        end
    endtask

    // MUL 25 x 3; a second request at cycle 10 must be ignored.
    task automatic test_ignore_busy();
        int pulses;
        int lat;
        logic [31:0] res;
        logic busy_seen;
        @(negedge clk);
        mb.operation = 2'b00; mb.multiplicand = 32'd25; mb.multiplier = 32'd3;
        mb.data_valid = 1'b1;
        @(posedge clk);
        #1;
        mb.data_valid = 1'b0;
        pulses = 0; lat = -1; res = 32'hDEAD_BEEF; busy_seen = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if (k == 10) begin
                mb.multiplicand = 32'd5; mb.multiplier = 32'd32; mb.data_valid = 1'b1;
            end else begin
                mb.data_valid = 1'b0;
            end
            if (k >= 10 && k <= XLEN + 1 && !mb.busy) busy_seen = 1'b0;
            if (mb.data_ready) begin
                pulses++;
                if (lat < 0) begin lat = k; res = mb.product_o; end
            end
        end
        total_cnt++;
        if (res !== 32'd75 || lat != XLEN + 1) begin
            $display("FAIL ignore_busy result: got %0d at lat %0d, required 75 at lat %0d",
                     res, lat, XLEN + 1);
        end else pass_cnt++;
        total_cnt++;
        if (pulses != 1 || !busy_seen) begin
            $display("FAIL ignore_busy pulses: got pulses=%0d busy_held=%b, required 1/1",
                     pulses, busy_seen);
        end else pass_cnt++;
    endtask

    // A request raised in the data_ready cycle must be dropped.
    task automatic test_ready_cycle();
        int pulses;
        logic busy_after;
        @(negedge clk);
        mb.operation = 2'b00; mb.multiplicand = 32'd3; mb.multiplier = 32'd4;
        mb.data_valid = 1'b1;
        @(posedge clk);
        #1;
        mb.data_valid = 1'b0;
        for (int k = 1; k <= 45 && !mb.data_ready; k++) begin
            @(posedge clk);
            #1;
        end
        mb.multiplicand = 32'd9; mb.multiplier = 32'd9; mb.data_valid = mb.data_ready;
        @(posedge clk);
        #1;
        mb.data_valid = 1'b0;
        busy_after = mb.busy;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (mb.data_ready) pulses++;
        end
        total_cnt++;
        if (busy_after !== 1'b0 || pulses != 0 || mb.product_o !== 32'd12) begin
            $display("FAIL ready_cycle_ignore: got busy=%b pulses=%0d product=%0d, required 0/0/12",
                     busy_after, pulses, mb.product_o);
        end else pass_cnt++;
    endtask

    // MUL 14 x 2 aborted by reset at cycle 15, then MUL 6 x 7.
    task automatic test_abort_reset();
        int pulses;
        logic [31:0] res, held;
        int lat;
        @(negedge clk);
        mb.operation = 2'b00; mb.multiplicand = 32'd14; mb.multiplier = 32'd2;
        mb.data_valid = 1'b1;
        @(posedge clk);
        #1;
        mb.data_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (mb.product_o !== 32'd0 || mb.busy !== 1'b0 || mb.data_ready !== 1'b0) begin
            $display("FAIL abort_outputs: product_o=%h busy=%b data_ready=%b, required 0/0/0",
                     mb.product_o, mb.busy, mb.data_ready);
        end else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk);
            #1;
            if (mb.data_ready) pulses++;
        end
        total_cnt++;
        if (pulses != 0 || mb.busy !== 1'b0) begin
            $display("FAIL abort_no_pulse: got pulses=%0d busy=%b, required 0/0", pulses, mb.busy);
        end else pass_cnt++;
        run_op(2'b00, 32'd6, 32'd7, res, lat, pulses, held);
        total_cnt++;
        if (res !== 32'd42 || pulses != 1) begin
            $display("FAIL abort_recover: got %0d pulses=%0d, required 42 pulses=1", res, pulses);
        end else pass_cnt++;
    endtask

    // Requests held high continuously: each result correct, pulses isolated.
    task automatic test_back_to_back();
        int pulses;
        logic bad;
        logic prev;
        @(negedge clk);
        mb.operation = 2'b01; mb.multiplicand = 32'hFFFF_FFF7; mb.multiplier = 32'h1234_5678;
        mb.data_valid = 1'b1;
        pulses = 0; bad = 1'b0; prev = 1'b0;
        for (int k = 0; k < 110; k++) begin
            @(posedge clk);
            #1;
            if (mb.data_ready) begin
                pulses++;
                if (prev || mb.product_o !== ref_mul(2'b01, 32'hFFFF_FFF7, 32'h1234_5678)) bad = 1'b1;
            end
            prev = mb.data_ready;
        end
        mb.data_valid = 1'b0;
        repeat (40) @(posedge clk);
        total_cnt++;
        if (pulses != 3 || bad) begin
            $display("FAIL back_to_back: got pulses=%0d bad=%b, required pulses=3 bad=0", pulses, bad);
        end else pass_cnt++;
    endtask

    task automatic test_zero();
        logic [31:0] res, held;
        int lat, pulses;
        run_op(2'b00, 32'd0, 32'd5, res, lat, pulses, held);
        total_cnt++;
        if (res !== 32'd0 || lat != exp_latency(32'd0, 32'd5) || pulses != 1) begin
            $display("FAIL zero_operand: got %h lat=%0d pulses=%0d, required 0 lat=%0d pulses=1",
                     res, lat, pulses, exp_latency(32'd0, 32'd5));
        end else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_busy();
        test_ready_cycle();
        test_abort_reset();
        test_back_to_back();
        test_zero();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
